mem_app_arb: RTL and testbench
==============================

Name: mem_app_arb

Overview:
- Two-requester arbiter sharing one Virtex-7 MIG native app interface (512-bit data, 28-bit address) between the background-model memory controller (port 0) and a secondary client such as a frame grabber or debug reader (port 1).
- Grants the interface in bursts of up to MAX_BURST commands with round-robin fairness.
- Records the requester ID of every accepted read and routes returned read data back in issue order.

Parameters:
- MAX_BURST, 64, max commands accepted per grant before forced re-arbitration (power of 2, >=2).
- TAG_DEPTH, 32, read-tag FIFO depth, i.e. max outstanding reads (power of 2).
- TAG_AW, 5, log2(TAG_DEPTH).

Ports:
- clk  in  1  MIG ui_clk; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rqN_addr  in  28  port N command address (N=0,1).
- rqN_cmd  in  3  port N command: 3'b001 read, 3'b000 write; other codes are treated as write.
- rqN_en  in  1  port N command valid; held until accepted.
- rqN_wdf_data  in  512  port N write data, presented together with its write command.
- rqN_rdy  out  1  port N command (and write data) accepted this cycle when rqN_en=1.
- rqN_rd_valid  out  1  returned read beat belongs to port N.
- rd_data  out  512  returned read data, shared by both ports (= app_rd_data).
- app_addr, app_cmd, app_en  out  28/3/1  MIG command.
- app_rdy  in  1  MIG command ready.
- app_wdf_data  out  512  MIG write data.
- app_wdf_wren, app_wdf_end  out  1/1  MIG write strobe / last beat.
- app_wdf_rdy  in  1  MIG write FIFO ready.
- app_rd_data  in  512  MIG read data.
- app_rd_data_valid  in  1  MIG read data valid.
- app_hi_pri  out  1  tied 0.
- outstanding  out  TAG_AW+1  reads issued but not yet returned.
- status  out  2  sticky errors: [0] read data with tag FIFO empty, [1] tag push while full.

Behaviour:
- Reset values: state IDLE, burst counter 0, last-granted = 1 (port 0 wins first tie), tag FIFO empty, outstanding 0, status 0. All rdy/en/wren/rd_valid outputs are 0 while rst_n=0.
- Reset mid-operation: any grant is dropped and the tag FIFO is flushed; in-flight MIG reads returning after reset set status[0].
- State machine: IDLE, GNT0, GNT1.
  - IDLE: if exactly one rqN_en is high, go to GNTN. If both are high, grant the port that is not last-granted. The grant takes effect the next cycle, so there is a one-cycle bubble from IDLE.
- Command muxing: in GNTN, app_addr/app_cmd/app_wdf_data come from port N; otherwise they come from port 0 with app_en=0.
- Acceptance for the granted port N:
  - is_rd = (rqN_cmd==3'b001).
  - app_en = rqN_en & (is_rd ? ~tag_full : app_wdf_rdy).
  - rqN_rdy = app_en & app_rdy.
  - For writes: app_wdf_wren = app_wdf_end = rqN_en & ~is_rd & app_rdy & app_wdf_rdy. One 512-bit beat per command, so the write data strobe and the command handshake complete in the same cycle.
  - The non-granted port's rdy is 0.
- Burst counter: increments on each accept and clears on a grant change.
- Release from GNTN happens on an accept when counter==MAX_BURST-1, or in any cycle where rqN_en=0. On release:
  - other port requesting -> GNT(other) directly, with no bubble;
  - else own port still requesting (burst limit hit) -> re-grant N with counter cleared;
  - else -> IDLE.
  - last-granted is updated to N.
- Tag FIFO:
  - Push the 1-bit ID N on every accepted read.
  - Pop on app_rd_data_valid; the popped ID selects which rqN_rd_valid pulses, in the same cycle as app_rd_data_valid (combinational from the FIFO head, zero latency).
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - app_rd_data_valid with FIFO empty: no rd_valid is asserted and status[0] is set.
  - tag_full blocks read acceptance only; writes still proceed.
- outstanding equals the tag FIFO count, with the same update rules.

Test Plan:
- Single port: port 0 issues 4 reads at addr 0x40,0x80,0xC0,0x100 with app_rdy=1 -> app_en high 4 cycles with matching app_addr. 4 returned beats pulse rq0_rd_valid only. outstanding goes 0->4->0.
- Contention: both ports continuously request writes, MAX_BURST=4 -> grants alternate 4 accepts port 0, 4 accepts port 1, ...; no gap at handover. Port 0 is granted first after reset.
- Backpressure: port 1 write with app_rdy=1, app_wdf_rdy=0 for 3 cycles -> app_wdf_wren=0 and rq1_rdy=0 for those 3 cycles. Accept occurs on the 4th cycle; exactly one wdf beat.
- Tag full: TAG_DEPTH=4, MIG withholds read data, port 0 issues 6 reads -> 4 accepted, then rq0_rdy=0 with outstanding=4. A port 0 write is still accepted. One returned beat allows the 5th read.
- Ordering: interleaved reads R0,R1,R0 accepted, 3 beats returned with distinct data -> rq0_rd_valid, rq1_rd_valid, rq0_rd_valid in that order with matching rd_data.
- Reset mid-burst: assert rst_n=0 with 2 reads outstanding, release, then MIG returns 1 beat -> no rd_valid, status[0]=1, state IDLE, outstanding 0.

Source files
------------

// File: rtl/mem_app_arb_if.sv
// Requester-side command port of the MIG app arbiter.
// One instance per client: command address/opcode/write data in, accept and read-return strobe out.
// master = client side, slave = arbiter side.
interface mem_app_arb_if;
  logic [27:0]  addr;      // command address
  logic [2:0]   cmd;       // 3'b001 read, anything else write
  logic         en;        // command valid, held until rdy
  logic [511:0] wdf_data;  // write beat, presented with its write command
  logic         rdy;       // command (and write beat) taken this cycle
  logic         rd_valid;  // shared rd_data beat belongs to this client

  modport master (
    output addr, cmd, en, wdf_data,
    input  rdy, rd_valid
  );

  modport slave (
    input  addr, cmd, en, wdf_data,
    output rdy, rd_valid
  );
endinterface

// File: rtl/mem_app_arb.sv
// Two-client round-robin burst arbiter onto one MIG native app interface, with in-order read return routing.
// Latency: one idle bubble when granting from IDLE, none at handover; read-return routing is combinational.
// Backpressure: rqN_rdy follows app_rdy/app_wdf_rdy; reads also stall while the read-tag FIFO is full.
//
// Ports: clk/rst_n; rq0/rq1 client command ports (mem_app_arb_if.slave); app_* MIG command, write-data and
// read-data channels; rd_data shared return data; outstanding = reads in flight; status = sticky errors
// ([0] read data returned with no tag, [1] tag push while full).
module mem_app_arb #(
  parameter int MAX_BURST = 64,
  parameter int TAG_DEPTH = 32,
  parameter int TAG_AW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_app_arb_if.slave       rq0,
  mem_app_arb_if.slave       rq1,
  output logic [511:0]       rd_data,
  output logic [27:0]        app_addr,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  input  logic               app_rdy,
  output logic [511:0]       app_wdf_data,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  input  logic               app_wdf_rdy,
  input  logic [511:0]       app_rd_data,
  input  logic               app_rd_data_valid,
  output logic               app_hi_pri,
  output logic [TAG_AW:0]    outstanding,
  output logic [1:0]         status
);

  localparam int BW = $clog2(MAX_BURST);
  localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TAG_AW:0] TAG_FULL_CNT = (TAG_AW + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
  logic                   last_gnt_q, last_gnt_d;
  logic [TAG_DEPTH-1:0]   tag_mem_q, tag_mem_d;
  logic [TAG_AW-1:0]      tag_wr_ptr_q, tag_wr_ptr_d;
  logic [TAG_AW-1:0]      tag_rd_ptr_q, tag_rd_ptr_d;
  logic [TAG_AW:0]        tag_cnt_q, tag_cnt_d;
  logic [1:0]             status_q, status_d;

  logic sel;        // granted port index (valid only when granted)
  logic granted;
  logic req_en;     // en of the granted port
  logic oth_en;     // en of the other port
  logic is_rd;
  logic accept;
  logic tag_full, tag_empty, tag_head;
  logic push_req, push, pop;

  assign tag_full  = (tag_cnt_q == TAG_FULL_CNT);
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_head  = tag_mem_q[tag_rd_ptr_q];

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_gnt_q   <= 1'b1;  // so port 0 wins the first tie
      tag_mem_q    <= '0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      tag_cnt_q    <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_gnt_q   <= last_gnt_d;
      tag_mem_q    <= tag_mem_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
      status_q     <= status_d;
    end
  end

  // ---------------------------------------------------------------- output / command mux
  always_comb begin
    sel          = (state_q == GNT1);
    granted      = (state_q != IDLE);
    req_en       = sel ? rq1.en : rq0.en;
    oth_en       = sel ? rq0.en : rq1.en;
    app_addr     = sel ? rq1.addr     : rq0.addr;
    app_cmd      = sel ? rq1.cmd      : rq0.cmd;
    app_wdf_data = sel ? rq1.wdf_data : rq0.wdf_data;
    is_rd        = (app_cmd == 3'b001);
    // Reads need a free tag slot; writes need room for their single data beat.
    app_en       = granted & req_en & (is_rd ? ~tag_full : app_wdf_rdy);
    accept       = app_en & app_rdy;
    rq0.rdy      = accept & ~sel;
    rq1.rdy      = accept & sel;
    app_wdf_wren = granted & req_en & ~is_rd & app_rdy & app_wdf_rdy;
    app_wdf_end  = app_wdf_wren;
    app_hi_pri   = 1'b0;
  end

  // ---------------------------------------------------------------- next-state
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_gnt_d  = last_gnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (rq0.en && rq1.en) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (rq0.en)      state_d = GNT0;
        else if (rq1.en)      state_d = GNT1;
      end
      GNT0, GNT1: begin
        if ((accept && burst_cnt_q == BURST_LAST) || !req_en) begin
          last_gnt_d  = sel;
          burst_cnt_d = '0;
          // Hand straight to the other port to avoid a bubble; a port that hit its
          // burst limit with nobody else waiting simply gets a fresh burst.
          if (oth_en)      state_d = sel ? GNT0 : GNT1;
          else if (req_en) state_d = state_q;
          else             state_d = IDLE;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- read-tag FIFO
  always_comb begin
    push_req     = accept & is_rd;
    pop          = app_rd_data_valid & ~tag_empty;
    push         = push_req & (~tag_full | pop);
    tag_mem_d    = tag_mem_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    tag_cnt_d    = tag_cnt_q;
    if (push) begin
      tag_mem_d[tag_wr_ptr_q] = sel;
      tag_wr_ptr_d            = tag_wr_ptr_q + TAG_AW'(1);
    end
    if (pop) tag_rd_ptr_d = tag_rd_ptr_q + TAG_AW'(1);
    case ({push, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + (TAG_AW + 1)'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - (TAG_AW + 1)'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
    status_d = status_q | {push_req & tag_full & ~pop, app_rd_data_valid & tag_empty};
  end

  // Return beats are steered from the FIFO head in the same cycle they arrive.
  assign rq0.rd_valid = pop & ~tag_head;
  assign rq1.rd_valid = pop & tag_head;
  assign rd_data      = app_rd_data;
  assign outstanding  = tag_cnt_q;
  assign status       = status_q;

endmodule

// File: tb/tb_mem_app_arb.sv
// Directed bench for mem_app_arb with MAX_BURST=4, TAG_DEPTH=4.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
// Expected values are hand-derived constants per scenario.
module tb_mem_app_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] rd_data;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [511:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_hi_pri;
  logic [2:0]   outstanding;
  logic [1:0]   status;

  always #5 clk = ~clk;

  mem_app_arb_if rq0_if ();
  mem_app_arb_if rq1_if ();

  mem_app_arb #(.MAX_BURST(4), .TAG_DEPTH(4), .TAG_AW(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rq0               (rq0_if.slave),
    .rq1               (rq1_if.slave),
    .rd_data           (rd_data),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_hi_pri        (app_hi_pri),
    .outstanding       (outstanding),
    .status            (status)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic en, input logic [2:0] cmd,
                         input logic [27:0] addr, input logic [63:0] d);
    if (p == 0) begin
      rq0_if.en = en; rq0_if.cmd = cmd; rq0_if.addr = addr; rq0_if.wdf_data = {448'd0, d};
    end else begin
      rq1_if.en = en; rq1_if.cmd = cmd; rq1_if.addr = addr; rq1_if.wdf_data = {448'd0, d};
    end
  endtask

  task automatic set_ret(input logic v, input logic [63:0] d);
    app_rd_data_valid = v;
    app_rd_data       = {448'd0, d};
  endtask

  // Present one command, wait (bounded) for its accept, then drop en.
  task automatic issue(input int p, input logic [2:0] cmd, input logic [27:0] addr, input string tag);
    logic ok;
    ok = 1'b0;
    set_req(p, 1'b1, cmd, addr, 64'h0);
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      ok = (p == 0) ? rq0_if.rdy : rq1_if.rdy;
      tick;
    end
    set_req(p, 1'b0, 3'b000, 28'h0, 64'h0);
    check_eq({tag, "_acc"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    set_req(0, 1'b0, 3'b000, 28'h0, 64'h0);
    set_req(1, 1'b0, 3'b000, 28'h0, 64'h0);
    set_ret(1'b0, 64'h0);
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] a1 [4];
    logic [2:0]  exp_p;
    a1 = '{28'h40, 28'h80, 28'hC0, 28'h100};

    // ---- reset state, with a request held during reset
    rst_n       = 1'b0;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    set_ret(1'b0, 64'h0);
    set_req(0, 1'b1, 3'b000, 28'h123, 64'h0);
    set_req(1, 1'b0, 3'b000, 28'h0, 64'h0);
    @(negedge clk); #1;
    check_eq("rst_app_en", app_en, 0);
    check_eq("rst_rq0_rdy", rq0_if.rdy, 0);
    check_eq("rst_wren", app_wdf_wren, 0);
    check_eq("rst_rdv", {rq1_if.rd_valid, rq0_if.rd_valid}, 0);
    check_eq("rst_outst", outstanding, 0);
    check_eq("rst_status", status, 0);
    check_eq("rst_hi_pri", app_hi_pri, 0);
    do_reset;

    // ---- single port: 4 reads from port 0
    set_req(0, 1'b1, 3'b001, a1[0], 64'h0);
    #1 check_eq("t1_bubble", app_en, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      rq0_if.addr = a1[i];
      #1;
      check_eq("t1_app_en", app_en, 1);
      check_eq("t1_addr", app_addr, a1[i]);
      check_eq("t1_cmd", app_cmd, 3'b001);
      check_eq("t1_rq0_rdy", rq0_if.rdy, 1);
      check_eq("t1_rq1_rdy", rq1_if.rdy, 0);
      tick;
    end
    set_req(0, 1'b0, 3'b000, 28'h0, 64'h0);
    #1 check_eq("t1_outst4", outstanding, 4);
    tick;
    for (int i = 0; i < 4; i++) begin
      set_ret(1'b1, 64'hA0 + 64'(i));
      #1;
      check_eq("t1_rdv0", rq0_if.rd_valid, 1);
      check_eq("t1_rdv1", rq1_if.rd_valid, 0);
      check_eq("t1_data", rd_data[63:0], 64'hA0 + 64'(i));
      tick;
    end
    set_ret(1'b0, 64'h0);
    #1 check_eq("t1_outst0", outstanding, 0);

    // ---- contention: continuous writes, bursts of 4, port 0 first after reset
    do_reset;
    set_req(0, 1'b1, 3'b000, 28'h100, 64'hD0);
    set_req(1, 1'b1, 3'b000, 28'h200, 64'hD1);
    #1 check_eq("t2_bubble", app_en, 0);
    tick;
    for (int k = 0; k < 16; k++) begin
      exp_p = 3'((k / 4) % 2);
      #1;
      check_eq("t2_rq0_rdy", rq0_if.rdy, (exp_p == 0));
      check_eq("t2_rq1_rdy", rq1_if.rdy, (exp_p == 1));
      check_eq("t2_wren", app_wdf_wren, 1);
      check_eq("t2_addr", app_addr, (exp_p == 0) ? 28'h100 : 28'h200);
      check_eq("t2_wdata", app_wdf_data[63:0], (exp_p == 0) ? 64'hD0 : 64'hD1);
      tick;
    end
    set_req(0, 1'b0, 3'b000, 28'h0, 64'h0);
    set_req(1, 1'b0, 3'b000, 28'h0, 64'h0);
    tick;
    tick;

    // ---- backpressure: port 1 write, write FIFO not ready for 3 cycles
    set_req(1, 1'b1, 3'b000, 28'h300, 64'hE1);
    app_wdf_rdy = 1'b0;
    #1 check_eq("t3_bubble", app_wdf_wren, 0);
    tick;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("t3_stall_wren", app_wdf_wren, 0);
      check_eq("t3_stall_rdy", rq1_if.rdy, 0);
      tick;
    end
    app_wdf_rdy = 1'b1;
    #1;
    check_eq("t3_wren", app_wdf_wren, 1);
    check_eq("t3_wend", app_wdf_end, 1);
    check_eq("t3_rq1_rdy", rq1_if.rdy, 1);
    check_eq("t3_wdata", app_wdf_data[63:0], 64'hE1);
    tick;
    set_req(1, 1'b0, 3'b000, 28'h0, 64'h0);
    #1 check_eq("t3_one_beat", app_wdf_wren, 0);
    tick;

    // ---- tag full: 4 reads fill the FIFO, writes still pass
    set_req(0, 1'b1, 3'b001, 28'h400, 64'h0);
    tick;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("t4_rd_rdy", rq0_if.rdy, 1);
      tick;
    end
    #1;
    check_eq("t4_full_rdy", rq0_if.rdy, 0);
    check_eq("t4_full_en", app_en, 0);
    check_eq("t4_outst4", outstanding, 4);
    tick;
    #1 check_eq("t4_full_rdy2", rq0_if.rdy, 0);
    rq0_if.cmd = 3'b000;
    #1;
    check_eq("t4_wr_rdy", rq0_if.rdy, 1);
    check_eq("t4_wr_wren", app_wdf_wren, 1);
    tick;
    rq0_if.cmd = 3'b001;
    set_ret(1'b1, 64'hB0);
    #1;
    check_eq("t4_pop_rdy", rq0_if.rdy, 0);
    check_eq("t4_pop_rdv", rq0_if.rd_valid, 1);
    tick;
    set_ret(1'b0, 64'h0);
    #1;
    check_eq("t4_outst3", outstanding, 3);
    check_eq("t4_5th_rdy", rq0_if.rdy, 1);
    tick;
    set_req(0, 1'b0, 3'b000, 28'h0, 64'h0);
    #1 check_eq("t4_outst4b", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      set_ret(1'b1, 64'hB1 + 64'(i));
      #1 check_eq("t4_drain_rdv", rq0_if.rd_valid, 1);
      tick;
    end
    set_ret(1'b0, 64'h0);
    #1 check_eq("t4_outst0", outstanding, 0);
    check_eq("t4_status", status, 0);

    // ---- ordering: R0, R1, R0 then three distinct return beats
    issue(0, 3'b001, 28'h10, "t5_r0a");
    issue(1, 3'b001, 28'h20, "t5_r1");
    issue(0, 3'b001, 28'h30, "t5_r0b");
    #1 check_eq("t5_outst3", outstanding, 3);
    for (int i = 0; i < 3; i++) begin
      set_ret(1'b1, 64'hC0 + 64'(i));
      #1;
      check_eq("t5_rdv0", rq0_if.rd_valid, (i != 1));
      check_eq("t5_rdv1", rq1_if.rd_valid, (i == 1));
      check_eq("t5_data", rd_data[63:0], 64'hC0 + 64'(i));
      tick;
    end
    set_ret(1'b0, 64'h0);

    // ---- reset with reads in flight, then a stale return beat
    issue(0, 3'b001, 28'h50, "t6_r0a");
    issue(0, 3'b001, 28'h60, "t6_r0b");
    #1 check_eq("t6_outst2", outstanding, 2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outst", outstanding, 0);
    check_eq("t6_rst_en", app_en, 0);
    tick;
    rst_n = 1'b1;
    set_ret(1'b1, 64'hF0);
    #1 check_eq("t6_stale_rdv", {rq1_if.rd_valid, rq0_if.rd_valid}, 0);
    tick;
    set_ret(1'b0, 64'h0);
    #1;
    check_eq("t6_status", status, 2'b01);
    check_eq("t6_outst0", outstanding, 0);
    set_req(0, 1'b1, 3'b000, 28'h70, 64'h0);
    #1 check_eq("t6_idle_bubble", app_en, 0);
    tick;
    #1 check_eq("t6_regrant", app_en, 1);
    tick;
    set_req(0, 1'b0, 3'b000, 28'h0, 64'h0);
    tick;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
